// File: rtl/ex_stage.sv
// ex_stage: execute stage; computes the ALU result and registers it with the EX/MEM controls.
// Define EX_MULDIV_EN to build the iterative multiply/divide unit for ALUOp 11-13.
module ex_stage #(
   parameter int unsigned ITER = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] readData0,
   input  logic [15:0] readData1,
   input  logic [3:0]  ALUOp,
   input  logic        ReadMem,
   input  logic        WriteMem,
   input  logic [15:0] DataIn,
   input  logic [1:0]  quarter,
   input  logic        write,
   output logic [15:0] o_ALUResult,
   output logic        o_ReadMem,
   output logic        o_WriteMem,
   output logic        o_write,
   output logic [15:0] o_DataIn,
   output logic [1:0]  o_quarter,
   output logic        o_stall
);

   localparam int unsigned ShW = $clog2(ITER);

   logic [15:0] alu_res;

   always_comb begin
      alu_res = '0;
      case (ALUOp)
         4'd0:    alu_res = readData0 + readData1;
         4'd1:    alu_res = readData0 - readData1;
         4'd2:    alu_res = readData0 & readData1;
         4'd3:    alu_res = readData0 | readData1;
         4'd4:    alu_res = readData0 ^ readData1;
         4'd5:    alu_res = ~readData0;
         4'd6:    alu_res = readData0 << readData1[ShW-1:0];
         4'd7:    alu_res = readData0 >> readData1[ShW-1:0];
         4'd8:    alu_res = $signed(readData0) >>> readData1[ShW-1:0];
         4'd9:    alu_res = {15'd0, $signed(readData0) < $signed(readData1)};
         4'd10:   alu_res = readData1;
         default: alu_res = '0;
      endcase
   end

`ifdef EX_MULDIV_EN
   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e         state_q;
   logic [ShW-1:0] cnt_q;
   logic [3:0]     op_q;
   // MUL: a_q = shifting multiplicand, q_q = multiplier, acc_q = product.
   // DIV: a_q = divisor, q_q = dividend shifting out / quotient in, acc_q = remainder.
   logic [15:0]    a_q, q_q, acc_q;
   logic [15:0]    a_d, q_d, acc_d;
   logic           is_md;
   logic [16:0]    rem_sh;
   logic           rem_ge;

   assign is_md  = (ALUOp == 4'd11) || (ALUOp == 4'd12) || (ALUOp == 4'd13);
   assign rem_sh = {acc_q, q_q[15]};
   assign rem_ge = rem_sh >= {1'b0, a_q};

   always_comb begin
      if (op_q == 4'd11) begin
         acc_d = acc_q + (q_q[0] ? a_q : 16'd0);
         a_d   = a_q << 1;
         q_d   = q_q >> 1;
      end else begin
         acc_d = rem_ge ? 16'(rem_sh - {1'b0, a_q}) : rem_sh[15:0];
         a_d   = a_q;
         q_d   = {q_q[14:0], rem_ge};
      end
   end

   assign o_stall = rst_n && (((state_q == StIdle) && is_md) || (state_q == StBusy));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         op_q        <= '0;
         a_q         <= '0;
         q_q         <= '0;
         acc_q       <= '0;
         o_ALUResult <= '0;
         o_ReadMem   <= 1'b0;
         o_WriteMem  <= 1'b0;
         o_write     <= 1'b0;
         o_DataIn    <= '0;
         o_quarter   <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (is_md) begin
                  op_q       <= ALUOp;
                  a_q        <= (ALUOp == 4'd11) ? readData0 : readData1;
                  q_q        <= (ALUOp == 4'd11) ? readData1 : readData0;
                  acc_q      <= '0;
                  cnt_q      <= ShW'(ITER - 1);
                  state_q    <= StBusy;
                  o_ReadMem  <= 1'b0;
                  o_WriteMem <= 1'b0;
                  o_write    <= 1'b0;
               end else begin
                  o_ALUResult <= alu_res;
                  o_ReadMem   <= ReadMem;
                  o_WriteMem  <= WriteMem;
                  o_write     <= write;
                  o_DataIn    <= DataIn;
                  o_quarter   <= quarter;
               end
            end
            StBusy: begin
               a_q        <= a_d;
               q_q        <= q_d;
               acc_q      <= acc_d;
               o_ReadMem  <= 1'b0;
               o_WriteMem <= 1'b0;
               o_write    <= 1'b0;
               if (cnt_q == '0) begin
                  state_q <= StDone;
               end else begin
                  cnt_q <= cnt_q - ShW'(1);
               end
            end
            StDone: begin
               o_ALUResult <= (op_q == 4'd12) ? q_q : acc_q;
               o_ReadMem   <= ReadMem;
               o_WriteMem  <= WriteMem;
               o_write     <= write;
               o_DataIn    <= DataIn;
               o_quarter   <= quarter;
               state_q     <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end
`else
   assign o_stall = 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_ALUResult <= '0;
         o_ReadMem   <= 1'b0;
         o_WriteMem  <= 1'b0;
         o_write     <= 1'b0;
         o_DataIn    <= '0;
         o_quarter   <= '0;
      end else begin
         o_ALUResult <= alu_res;
         o_ReadMem   <= ReadMem;
         o_WriteMem  <= WriteMem;
         o_write     <= write;
         o_DataIn    <= DataIn;
         o_quarter   <= quarter;
      end
   end
`endif

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized self-checking bench for ex_stage against an arithmetic reference model.
// Expectations follow EX_MULDIV_EN when it is defined for the build.
module tb_ex_stage;

`ifdef EX_MULDIV_EN
   localparam bit MdEn = 1'b1;
`else
   localparam bit MdEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] readData0 = '0, readData1 = '0, DataIn = '0;
   logic [3:0]  ALUOp = '0;
   logic        ReadMem = 1'b0, WriteMem = 1'b0, write = 1'b0;
   logic [1:0]  quarter = '0;
   logic [15:0] o_ALUResult, o_DataIn;
   logic        o_ReadMem, o_WriteMem, o_write, o_stall;
   logic [1:0]  o_quarter;
   logic [20:0] act_ctrl;

   int n_cmp = 0;
   int n_fail = 0;

   // Last values the bench expects to be held on the outputs.
   logic [15:0] e_res = '0;
   logic [20:0] e_ctrl = '0;
   logic [20:0] in_ctrl = '0;

   always #5 clk = ~clk;

   assign act_ctrl = {o_ReadMem, o_WriteMem, o_write, o_quarter, o_DataIn};

   ex_stage #(.ITER(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .readData0  (readData0),
      .readData1  (readData1),
      .ALUOp      (ALUOp),
      .ReadMem    (ReadMem),
      .WriteMem   (WriteMem),
      .DataIn     (DataIn),
      .quarter    (quarter),
      .write      (write),
      .o_ALUResult(o_ALUResult),
      .o_ReadMem  (o_ReadMem),
      .o_WriteMem (o_WriteMem),
      .o_write    (o_write),
      .o_DataIn   (o_DataIn),
      .o_quarter  (o_quarter),
      .o_stall    (o_stall)
   );

   function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
      longint ua, ub, sh, sa, sb;
      ua = longint'(a);
      ub = longint'(b);
      sh = ub % 16;
      sa = (ua >= 32768) ? ua - 65536 : ua;
      sb = (ub >= 32768) ? ub - 65536 : ub;
      case (op)
         4'd0:  return 16'((ua + ub) % 65536);
         4'd1:  return 16'((ua + 65536 - ub) % 65536);
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return a ^ b;
         4'd5:  return ~a;
         4'd6:  return 16'((ua * (longint'(1) << sh)) % 65536);
         4'd7:  return 16'(ua / (longint'(1) << sh));
         4'd8:  return 16'((ua / (longint'(1) << sh)) +
                           (a[15] ? (65536 - (65536 / (longint'(1) << sh))) : 0));
         4'd9:  return (sa < sb) ? 16'd1 : 16'd0;
         4'd10: return b;
         4'd11: return MdEn ? 16'((ua * ub) % 65536) : 16'd0;
         4'd12: return MdEn ? ((ub == 0) ? 16'hFFFF : 16'(ua / ub)) : 16'd0;
         4'd13: return MdEn ? ((ub == 0) ? a : 16'(ua % ub)) : 16'd0;
         default: return 16'd0;
      endcase
   endfunction

   task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic rm, input logic wm, input logic w, input logic [1:0] q,
                        input logic [15:0] din);
      ALUOp     = op;
      readData0 = a;
      readData1 = b;
      ReadMem   = rm;
      WriteMem  = wm;
      write     = w;
      quarter   = q;
      DataIn    = din;
      in_ctrl   = {rm, wm, w, q, din};
   endtask

   task automatic test_reset();
      drive(4'd0, 16'h1234, 16'h1111, 1'b1, 1'b1, 1'b1, 2'd3, 16'hBEEF);
      #1;
      n_cmp++;
      if ({o_ALUResult, act_ctrl, o_stall} !== 38'd0) begin
         n_fail++;
         $display("FAIL reset_initial: got res=%h ctrl=%h stall=%b want all 0",
                  o_ALUResult, act_ctrl, o_stall);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (o_ALUResult !== 16'h2345 || act_ctrl !== in_ctrl) begin
         n_fail++;
         $display("FAIL reset_preload: got res=%h ctrl=%h want res=2345 ctrl=%h",
                  o_ALUResult, act_ctrl, in_ctrl);
      end
      drive(4'd11, 16'd3, 16'd5, 1'b1, 1'b0, 1'b1, 2'd1, 16'h5555);
      if (MdEn) begin
         @(posedge clk); #1;
         @(posedge clk); #1;
         n_cmp++;
         if (o_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_busy_stall: got %b want 1", o_stall);
         end
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({o_ALUResult, act_ctrl, o_stall} !== 38'd0) begin
         n_fail++;
         $display("FAIL reset_midop: got res=%h ctrl=%h stall=%b want all 0",
                  o_ALUResult, act_ctrl, o_stall);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'd0, 16'd1, 16'd1, 1'b0, 1'b1, 1'b1, 2'd2, 16'h00A5);
      #1;
      n_cmp++;
      if (o_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_add_stall: got %b want 0", o_stall);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (o_ALUResult !== 16'h0002 || act_ctrl !== in_ctrl) begin
         n_fail++;
         $display("FAIL reset_add: got res=%h ctrl=%h want res=0002 ctrl=%h",
                  o_ALUResult, act_ctrl, in_ctrl);
      end
      e_res  = 16'h0002;
      e_ctrl = in_ctrl;
   endtask

   task automatic test_alu();
      logic [3:0]  d_op [3];
      logic [15:0] d_a [3];
      logic [15:0] d_b [3];
      logic [3:0]  op;
      logic [15:0] a, b, exp;
      d_op = '{4'd0, 4'd8, 4'd9};
      d_a  = '{16'hFFFF, 16'h8000, 16'hFFFF};
      d_b  = '{16'h0001, 16'h0004, 16'h0001};
      for (int i = 0; i < 48; i++) begin
         if (i < 3) begin
            op = d_op[i];
            a  = d_a[i];
            b  = d_b[i];
         end else begin
            op = 4'($urandom_range(0, 15));
            if (MdEn && op >= 4'd11 && op <= 4'd13) op = 4'd14;
            a = 16'($urandom);
            b = (i % 3 == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
         end
         drive(op, a, b, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
               16'($urandom));
         exp = ref_alu(op, a, b);
         if (i == 0) exp = 16'h0000;
         if (i == 1) exp = 16'hF800;
         if (i == 2) exp = 16'h0001;
         #1;
         n_cmp++;
         if (o_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_stall[%0d]: got %b want 0", i, o_stall);
         end
         @(posedge clk); #1;
         n_cmp++;
         if (o_ALUResult !== exp) begin
            n_fail++;
            $display("FAIL alu_res[%0d] op=%0d a=%h b=%h: got %h want %h",
                     i, op, a, b, o_ALUResult, exp);
         end
         n_cmp++;
         if (act_ctrl !== in_ctrl) begin
            n_fail++;
            $display("FAIL alu_ctrl[%0d]: got %h want %h", i, act_ctrl, in_ctrl);
         end
         e_res  = exp;
         e_ctrl = in_ctrl;
      end
   endtask

`ifdef EX_MULDIV_EN
   task automatic run_md(input string name, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp, input logic wm);
      int cyc;
      logic [20:0] bub;
      cyc = 0;
      drive(op, a, b, 1'($urandom), wm, 1'b1, 2'($urandom), 16'($urandom));
      #1;
      while (o_stall === 1'b1 && cyc < 40) begin
         cyc++;
         @(posedge clk); #1;
         bub = {3'b000, e_ctrl[17:0]};
         n_cmp++;
         if (o_ALUResult !== e_res || act_ctrl !== bub) begin
            n_fail++;
            $display("FAIL %s_bubble[%0d]: got res=%h ctrl=%h want res=%h ctrl=%h",
                     name, cyc, o_ALUResult, act_ctrl, e_res, bub);
         end
         e_ctrl = bub;
      end
      n_cmp++;
      if (cyc != 17) begin
         n_fail++;
         $display("FAIL %s_stall_cycles: got %0d want 17", name, cyc);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (o_ALUResult !== exp || act_ctrl !== in_ctrl) begin
         n_fail++;
         $display("FAIL %s_result: got res=%h ctrl=%h want res=%h ctrl=%h",
                  name, o_ALUResult, act_ctrl, exp, in_ctrl);
      end
      e_res  = exp;
      e_ctrl = in_ctrl;
   endtask

   task automatic test_muldiv();
      logic [3:0]  op;
      logic [15:0] a, b;
      run_md("mul_0123x0010", 4'd11, 16'h0123, 16'h0010, 16'h1230, 1'b0);
      run_md("divu_100_7", 4'd12, 16'd100, 16'd7, 16'h000E, 1'b0);
      run_md("remu_100_7", 4'd13, 16'd100, 16'd7, 16'h0002, 1'b0);
      run_md("divu_by0", 4'd12, 16'h1234, 16'h0000, 16'hFFFF, 1'b0);
      run_md("remu_by0", 4'd13, 16'h1234, 16'h0000, 16'h1234, 1'b0);
      for (int i = 0; i < 6; i++) begin
         op = 4'($urandom_range(11, 13));
         a  = 16'($urandom);
         b  = (i == 5) ? 16'd0 : 16'($urandom_range(1, 65535) >> $urandom_range(0, 12));
         run_md("md_rand", op, a, b, ref_alu(op, a, b), 1'($urandom));
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] a, b, exp;
      run_md("b2b_mul", 4'd11, 16'd7, 16'd9, 16'd63, 1'b1);
      a   = 16'($urandom);
      b   = 16'($urandom);
      exp = ref_alu(4'd0, a, b);
      drive(4'd0, a, b, 1'b0, 1'b0, 1'b1, 2'd2, 16'($urandom));
      #1;
      n_cmp++;
      if (o_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_retrigger: got stall=%b want 0", o_stall);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (o_ALUResult !== exp || act_ctrl !== in_ctrl) begin
         n_fail++;
         $display("FAIL b2b_add: got res=%h ctrl=%h want res=%h ctrl=%h",
                  o_ALUResult, act_ctrl, exp, in_ctrl);
      end
      e_res  = exp;
      e_ctrl = in_ctrl;
   endtask
`else
   task automatic test_nomuldiv();
      for (int op = 11; op <= 13; op++) begin
         drive(4'(op), 16'd3, 16'd5, 1'b1, 1'b1, 1'b1, 2'(op), 16'($urandom));
         #1;
         n_cmp++;
         if (o_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL nomd_stall op=%0d: got %b want 0", op, o_stall);
         end
         @(posedge clk); #1;
         n_cmp++;
         if (o_ALUResult !== 16'h0000 || act_ctrl !== in_ctrl || o_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL nomd_op%0d: got res=%h ctrl=%h stall=%b want res=0000 ctrl=%h",
                     op, o_ALUResult, act_ctrl, o_stall, in_ctrl);
         end
         e_res  = 16'h0000;
         e_ctrl = in_ctrl;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_alu();
`ifdef EX_MULDIV_EN
      test_muldiv();
      test_back_to_back();
`else
      test_nomuldiv();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 16-bit pipeline. It sits between the ID/EX latch and the MEM stage. It consumes the ID/EX outputs (operands, ALUOp, memory controls, store data, quarter, write) and computes the ALU result. It registers that result with the pass-through controls as the EX/MEM boundary. Single-cycle ops complete in one clock; optional multiply/divide ops run iteratively and stall the front of the pipeline.

## Interface
Parameters:
- ITER, 16: number of multiply/divide iterations (must equal the operand width, 16).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- readData0  in  16  operand A (from ID/EX)
- readData1  in  16  operand B (from ID/EX)
- ALUOp  in  4  operation select
- ReadMem, WriteMem  in  1 each  memory controls, passed through
- DataIn  in  16  store data, passed through
- quarter  in  2  destination register select, passed through
- write  in  1  register-file write enable, passed through
- o_ALUResult  out  16  registered result
- o_ReadMem, o_WriteMem, o_write  out  1 each  registered controls
- o_DataIn  out  16  registered store data
- o_quarter  out  2  registered destination select
- o_stall  out  1  combinational; high means upstream stages (PC, IF/ID, ID/EX) must hold

## Operation
ALUOp encoding (A = readData0, B = readData1; all results mod 2^16):
- 0 ADD: A+B.
- 1 SUB: A−B.
- 2 AND.
- 3 OR.
- 4 XOR.
- 5 NOT A.
- 6 SLL: A<<B[3:0].
- 7 SRL: logical shift right by B[3:0].
- 8 SRA: arithmetic shift right by B[3:0].
- 9 SLT: signed compare, result 1 if A<B else 0.
- 10 PASSB: B.
- 11 MUL: low 16 bits of unsigned A×B.
- 12 DIVU: unsigned quotient.
- 13 REMU: unsigned remainder.
- 14, 15: reserved, result 0x0000.

Divide by zero: DIVU returns 0xFFFF; REMU returns A.

The FSM has three states: IDLE, BUSY, DONE.
- IDLE with a single-cycle op: at the edge, all o_* load the result and pass-through inputs.
- IDLE with ALUOp 11–13: o_stall=1 immediately (combinational).
  - At the edge, capture A, B and op, and load the iteration counter with ITER−1.
  - Go to BUSY.
  - Load a bubble: o_write=o_ReadMem=o_WriteMem=0, other outputs hold.
- BUSY: one shift-add (MUL) or restoring shift-subtract (DIVU/REMU) step per edge. o_stall=1. A bubble is loaded each edge.
  - After ITER steps (counter reaches 0), go to DONE.
- DONE: o_stall=0. Upstream still presents the same instruction, because it was held.
  - At the edge, o_ALUResult loads the mul/div result and the pass-through fields load from the current inputs.
  - Go to IDLE. The op is not re-triggered.
- Overflow is ignored for all operations; no flags are produced.

## Timing
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE and the counter to 0.
  - All o_* go to 0 and o_stall goes to 0.
  - Reset during BUSY aborts the operation with no result.
- Single-cycle op: latency 1 edge, with no stall.
- Mul/div op presented before edge E0:
  - o_stall is high before E0 through E16, which is 17 cycles.
  - DONE holds during the cycle before E17.
  - Result is visible on o_* after E17.
  - Bubbles are visible after E0 through E16.
- Back-to-back mul/div: the second op is presented after E17. IDLE is entered at E17, so its stall begins in the cycle after E17.
- Inputs must remain stable while o_stall=1. The block does not re-sample the pass-through fields until DONE.

## Configuration
- EX_MULDIV_EN defined: the multiply/divide datapath and BUSY/DONE states are built, as described above.
- EX_MULDIV_EN undefined: ALUOp 11–13 behave like reserved ops. They are single-cycle, give result 0x0000 and pass the controls through. o_stall is tied to 0 and no FSM is built.

## Test plan
- Reset: assert rst_n=0 mid-BUSY of MUL 3×5 -> all o_* = 0 and o_stall=0 immediately; after release, ADD 1+1 -> o_ALUResult=0x0002 after 1 edge.
- Single-cycle ALU ops:
  - ADD 0xFFFF+0x0001 -> 0x0000.
  - SRA 0x8000 by 0x0004 -> 0xF800.
  - SLT 0xFFFF,0x0001 -> 0x0001.
  - Each with the controls passed through in the same edge.
- MUL 0x0123×0x0010 -> o_stall high exactly 17 cycles, bubbles with o_write=0, then o_ALUResult=0x1230 with o_write=1 and o_quarter as input.
- DIVU 100/7 -> 0x000E; REMU 100/7 -> 0x0002; DIVU 0x1234/0 -> 0xFFFF; REMU 0x1234/0 -> 0x1234.
- Back-to-back MUL then ADD:
  - The ADD result appears one edge after the MUL result.
  - The MUL is not repeated.
  - WriteMem=1 on the MUL instruction is not seen on o_WriteMem during its bubbles.
- Build without EX_MULDIV_EN: MUL 3×5 -> o_ALUResult=0x0000 after 1 edge, and o_stall is never asserted.
